// File: rtl/game_pkg.sv
// Shared types and constants for the card-matching game controller:
// FSM states, UART command bytes and the layout-rotation LFSR.
package game_pkg;

    typedef enum logic [2:0] {
        WAIT = 3'd0,
        SHOW = 3'd1,
        GAME = 3'd2,
        HOLD = 3'd3,
        END  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_UP      = 8'h31;
    localparam logic [7:0] CMD_DOWN    = 8'h32;
    localparam logic [7:0] CMD_LEFT    = 8'h33;
    localparam logic [7:0] CMD_RIGHT   = 8'h34;
    localparam logic [7:0] CMD_OPEN    = 8'h35;
    localparam logic [7:0] CMD_RESTART = 8'h36;

    // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game_timer.sv
// Game clock: counts video frames into seconds and counts left_time down.
// Mismatch penalties are applied only when GAME_PENALTY_EN is defined.
module game_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int GAME_SECONDS   = 300,
    parameter int TIME_W         = 12,
    parameter int PENALTY_SEC    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic              frame_tick,
    input  logic              penalty,
    output logic [TIME_W-1:0] left_time
);

    localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);

    logic [FC_W-1:0]   frame_cnt;
    logic              sec_tick;
    logic [TIME_W-1:0] pen_dec;
    logic [TIME_W-1:0] dec;

    assign sec_tick = run && frame_tick && (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));

`ifdef GAME_PENALTY_EN
    assign pen_dec = (run && penalty) ? TIME_W'(PENALTY_SEC) : '0;
`else
    logic unused_penalty;
    assign unused_penalty = penalty ^ (PENALTY_SEC != 0);
    assign pen_dec        = '0;
`endif

    // A second boundary and a penalty on the same edge stack into one subtraction
    assign dec = pen_dec + (sec_tick ? TIME_W'(1) : TIME_W'(0));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            frame_cnt <= '0;
            left_time <= TIME_W'(GAME_SECONDS);
        end else if (!run) begin
            frame_cnt <= '0;
        end else begin
            if (frame_tick) begin
                frame_cnt <= sec_tick ? '0 : frame_cnt + FC_W'(1);
            end
            left_time <= (left_time > dec) ? left_time - dec : '0;
        end
    end

endmodule

// File: rtl/game_ctrl_grid.sv
// Card-matching game controller for a ROWS x COLS grid, between the UART
// command receiver and the renderer. GAME_PENALTY_EN enables time penalties.
module game_ctrl_grid
    import game_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int ID_W = 4,
    parameter logic [ROWS*COLS*ID_W-1:0] INIT_CARD_LOC = 64'h0714_2061_4352_3657,
    parameter int FRAMES_PER_SEC = 60,
    parameter int GAME_SECONDS   = 300,
    parameter int TIME_W         = 12,
    parameter int SHOW_CYC       = 125_000_000,
    parameter int HOLD_CYC       = 25_000_000,
    parameter int PENALTY_SEC    = 5,
    localparam int N     = ROWS * COLS,
    localparam int IDX_W = $clog2(N),
    localparam int MC_W  = $clog2(N / 2 + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_data,
    output state_t              state,
    output logic [IDX_W-1:0]    cursor,
    output logic                first_vld,
    output logic [IDX_W-1:0]    first_idx,
    output logic                second_vld,
    output logic [IDX_W-1:0]    second_idx,
    output logic [N-1:0]        card_found,
    output logic [N*ID_W-1:0]   card_loc,
    output logic [TIME_W-1:0]   left_time,
    output logic [MC_W-1:0]     match_cnt,
    output logic [15:0]         attempt_cnt
);

    localparam int LOC_W   = N * ID_W;
    localparam int CNT_MAX = (SHOW_CYC > HOLD_CYC) ? SHOW_CYC : HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_nxt;
    logic [7:0]         lfsr;
    logic [CNT_W-1:0]   phase_cnt, phase_nxt;
    logic [IDX_W-1:0]   cursor_nxt, first_idx_nxt, second_idx_nxt;
    logic               first_vld_nxt, second_vld_nxt;
    logic [N-1:0]       found_nxt;
    logic [LOC_W-1:0]   loc_nxt, loc_rot;
    logic [2*LOC_W-1:0] loc_dbl;
    logic [MC_W-1:0]    match_nxt;
    logic [15:0]        attempt_nxt;
    logic [ID_W-1:0]    id_cursor, id_first;
    logic               timer_run, timer_load, timer_penalty;
    logic               restart, all_found, open_ok;
    int unsigned        cur_i;

    // Right rotation by whole slots: shift a doubled copy and keep the low half
    assign loc_dbl   = {INIT_CARD_LOC, INIT_CARD_LOC} >> ((int'(lfsr) % N) * ID_W);
    assign loc_rot   = loc_dbl[LOC_W-1:0];

    assign cur_i     = 32'(cursor);
    assign id_cursor = card_loc[cur_i * ID_W +: ID_W];
    assign id_first  = card_loc[32'(first_idx) * ID_W +: ID_W];
    assign restart   = cmd_valid && (cmd_data == CMD_RESTART);
    assign all_found = &card_found;
    assign open_ok   = !card_found[cursor] && !(first_vld && (cursor == first_idx));
    assign timer_run = (state == GAME) || (state == HOLD);

    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase_cnt;
        cursor_nxt     = cursor;
        first_vld_nxt  = first_vld;
        first_idx_nxt  = first_idx;
        second_vld_nxt = second_vld;
        second_idx_nxt = second_idx;
        found_nxt      = card_found;
        loc_nxt        = card_loc;
        match_nxt      = match_cnt;
        attempt_nxt    = attempt_cnt;
        timer_load     = 1'b0;
        timer_penalty  = 1'b0;

        case (state)
            WAIT: begin
                if (cmd_valid) begin
                    state_nxt      = SHOW;
                    phase_nxt      = '0;
                    loc_nxt        = loc_rot;
                    found_nxt      = '0;
                    cursor_nxt     = '0;
                    first_vld_nxt  = 1'b0;
                    first_idx_nxt  = '0;
                    second_vld_nxt = 1'b0;
                    second_idx_nxt = '0;
                    match_nxt      = '0;
                    attempt_nxt    = '0;
                    timer_load     = 1'b1;
                end
            end
            SHOW: begin
                if (phase_cnt == CNT_W'(SHOW_CYC)) begin
                    state_nxt = GAME;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            GAME: begin
                if (restart) begin
                    state_nxt = WAIT;
                end else if (all_found || (left_time == '0)) begin
                    state_nxt = END;
                end else if (cmd_valid) begin
                    case (cmd_data)
                        CMD_UP:    if (cur_i >= COLS) cursor_nxt = cursor - IDX_W'(COLS);
                        CMD_DOWN:  if (cur_i < N - COLS) cursor_nxt = cursor + IDX_W'(COLS);
                        CMD_LEFT:  if (cur_i % COLS != 0) cursor_nxt = cursor - IDX_W'(1);
                        CMD_RIGHT: if (cur_i % COLS != COLS - 1) cursor_nxt = cursor + IDX_W'(1);
                        CMD_OPEN: begin
                            if (open_ok && !first_vld) begin
                                first_vld_nxt = 1'b1;
                                first_idx_nxt = cursor;
                            end else if (open_ok) begin
                                second_vld_nxt = 1'b1;
                                second_idx_nxt = cursor;
                                state_nxt      = HOLD;
                                phase_nxt      = '0;
                                if (attempt_cnt != 16'hFFFF) attempt_nxt = attempt_cnt + 16'd1;
                                if (id_cursor == id_first) begin
                                    found_nxt[cursor]    = 1'b1;
                                    found_nxt[first_idx] = 1'b1;
                                    match_nxt            = match_cnt + MC_W'(1);
                                end else begin
                                    timer_penalty = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            HOLD: begin
                if (restart) begin
                    state_nxt = WAIT;
                end else if (phase_cnt == CNT_W'(HOLD_CYC)) begin
                    first_vld_nxt  = 1'b0;
                    second_vld_nxt = 1'b0;
                    phase_nxt      = '0;
                    state_nxt      = (all_found || (left_time == '0)) ? END : GAME;
                end else begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            END: begin
                if (restart) state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT;
            lfsr        <= LFSR_SEED;
            phase_cnt   <= '0;
            cursor      <= '0;
            first_vld   <= 1'b0;
            first_idx   <= '0;
            second_vld  <= 1'b0;
            second_idx  <= '0;
            card_found  <= '0;
            card_loc    <= INIT_CARD_LOC;
            match_cnt   <= '0;
            attempt_cnt <= '0;
        end else begin
            state       <= state_nxt;
            lfsr        <= lfsr_next(lfsr);
            phase_cnt   <= phase_nxt;
            cursor      <= cursor_nxt;
            first_vld   <= first_vld_nxt;
            first_idx   <= first_idx_nxt;
            second_vld  <= second_vld_nxt;
            second_idx  <= second_idx_nxt;
            card_found  <= found_nxt;
            card_loc    <= loc_nxt;
            match_cnt   <= match_nxt;
            attempt_cnt <= attempt_nxt;
        end
    end

    game_timer #(
        .FRAMES_PER_SEC (FRAMES_PER_SEC),
        .GAME_SECONDS   (GAME_SECONDS),
        .TIME_W         (TIME_W),
        .PENALTY_SEC    (PENALTY_SEC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (timer_run),
        .load       (timer_load),
        .frame_tick (frame_tick),
        .penalty    (timer_penalty),
        .left_time  (left_time)
    );

endmodule
